// File: rtl/cac_uart_tx_arbiter_if.sv
// Handshake bundle between the CAC byte-stream requesters, the packet
// arbiter and the UART TX byte port. The arbiter takes the slave view.
// The master view is the environment (requesters plus UART).
interface cac_uart_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = 2
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]         tx_data;
    logic                          tx_valid;
    logic                          tx_ready;
    logic [ID_WIDTH-1:0]           grant_id;
    logic                          busy;
    logic                          timeout_pulse;

    modport master (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_data, tx_valid, grant_id, busy, timeout_pulse
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_data, tx_valid, grant_id, busy, timeout_pulse
    );
endinterface

// File: rtl/cac_uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing the CAC UART transmitter between
// NUM_REQ byte-stream sources. A granted source owns the UART until its
// req_last byte is accepted, so packets never interleave on the wire.
// Optional stall timeout: define CAC_UART_ARB_TIMEOUT_EN to abandon a packet
// whose owner stalls for TIMEOUT_CYCLES cycles (pulses timeout_pulse).
module cac_uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int ID_WIDTH       = 2,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                  clk_cac,
    input  logic                  rst,
    cac_uart_tx_arbiter_if.slave  bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Reject parameter sets the grant index or stall limit cannot represent.
    if ((2 ** ID_WIDTH) < NUM_REQ || NUM_REQ < 2 || DATA_WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("cac_uart_tx_arbiter: illegal parameter combination");
    end

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
    logic                  busy_q, busy_d;

    logic                  any_valid;
    logic [ID_WIDTH-1:0]   sel_idx;
    logic [ID_WIDTH-1:0]   cand;
    logic                  own_valid;
    logic                  own_last;
    logic [DATA_WIDTH-1:0] own_data;
    logic                  handshake;
    logic [ID_WIDTH-1:0]   next_ptr;

`ifdef CAC_UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic                  timeout_pulse_q, timeout_pulse_d;
`endif

    // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        any_valid = |bus.req_valid;
        sel_idx   = '0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ID_WIDTH'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (bus.req_valid[cand]) begin
                sel_idx = cand;
            end
        end
    end

    // Steer the current owner's valid/data/last onto internal wires.
    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == ID_WIDTH'(i)) begin
                own_valid = bus.req_valid[i];
                own_last  = bus.req_last[i];
                own_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        handshake = (state_q == LOCKED) && own_valid && bus.tx_ready;
        next_ptr  = (grant_id_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
    end

    // Next-state logic: grant in IDLE, release on the last byte (or stall timeout).
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;
`ifdef CAC_UART_ARB_TIMEOUT_EN
        stall_cnt_d     = stall_cnt_q;
        timeout_pulse_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d    = LOCKED;
                    grant_id_d = sel_idx;
                    busy_d     = 1'b1;
`ifdef CAC_UART_ARB_TIMEOUT_EN
                    stall_cnt_d = '0;
`endif
                end
            end
            LOCKED: begin
                if (handshake) begin
`ifdef CAC_UART_ARB_TIMEOUT_EN
                    stall_cnt_d = '0;
`endif
                    if (own_last) begin
                        state_d  = IDLE;
                        busy_d   = 1'b0;
                        rr_ptr_d = next_ptr;
                    end
                end else begin
`ifdef CAC_UART_ARB_TIMEOUT_EN
                    stall_cnt_d = stall_cnt_q + 1'b1;
                    if (stall_cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                        timeout_pulse_d = 1'b1;
                        state_d         = IDLE;
                        busy_d          = 1'b0;
                        rr_ptr_d        = next_ptr;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset; a mid-packet reset drops the packet.
    always_ff @(posedge clk_cac) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
`ifdef CAC_UART_ARB_TIMEOUT_EN
            stall_cnt_q     <= '0;
            timeout_pulse_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
`ifdef CAC_UART_ARB_TIMEOUT_EN
            stall_cnt_q     <= stall_cnt_d;
            timeout_pulse_q <= timeout_pulse_d;
`endif
        end
    end

    // Zero-latency pass-through of the owner's stream while LOCKED; quiet in IDLE.
    always_comb begin
        bus.tx_valid  = 1'b0;
        bus.tx_data   = '0;
        bus.req_ready = '0;
        if (state_q == LOCKED) begin
            bus.tx_valid = own_valid;
            bus.tx_data  = own_data;
            for (int i = 0; i < NUM_REQ; i++) begin
                bus.req_ready[i] = (grant_id_q == ID_WIDTH'(i)) && bus.tx_ready;
            end
        end
    end

    assign bus.grant_id = grant_id_q;
    assign bus.busy     = busy_q;
`ifdef CAC_UART_ARB_TIMEOUT_EN
    assign bus.timeout_pulse = timeout_pulse_q;
`else
    assign bus.timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_cac_uart_tx_arbiter.sv
// Self-checking bench for cac_uart_tx_arbiter: a constant vector table,
// hand-written multi-cycle sequences, then randomized traffic checked
// against a packet-level round-robin reference model.
module tb_cac_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int IDW  = 2;
    localparam int TO   = 8;

    logic clk_cac;
    logic rst;

    int compared;
    int mismatched;

    cac_uart_tx_arbiter_if #(.NUM_REQ(NREQ), .DATA_WIDTH(DW), .ID_WIDTH(IDW)) bus ();

    cac_uart_tx_arbiter #(
        .NUM_REQ(NREQ), .DATA_WIDTH(DW), .ID_WIDTH(IDW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_cac (clk_cac),
        .rst     (rst),
        .bus     (bus)
    );

    initial clk_cac = 1'b0;
    always #5 clk_cac = ~clk_cac;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  last;
        logic        txr;
        logic        e_tv;
        logic [7:0]  e_data;
        logic [3:0]  e_ready;
        logic [1:0]  e_grant;
        logic        e_busy;
    } vec_t;

    vec_t vecs [16];

    // Random-phase requester state and reference model state
    logic [7:0] cur_byte [NREQ];
    int         remain   [NREQ];
    int         m_owner;
    int         m_ptr;
    int         m_grant;
    int         m_stall;
    logic       m_pulse;
    int         moved;

    // Drive one cycle's inputs (called just after a rising edge).
    task automatic applyStimulus(input logic r, input logic [3:0] v, input logic [31:0] d,
                                 input logic [3:0] l, input logic txr);
        rst           = r;
        bus.req_valid = v;
        bus.req_data  = d;
        bus.req_last  = l;
        bus.tx_ready  = txr;
    endtask

    // Compare outputs at the falling edge, then advance past the next rising edge.
    task automatic checkOutput(input string name, input logic e_tv, input logic [7:0] e_data,
                               input logic [3:0] e_ready, input logic [1:0] e_grant,
                               input logic e_busy, input logic e_pulse);
        logic [16:0] act;
        logic [16:0] exp;
        @(negedge clk_cac);
        act = {bus.tx_valid, bus.tx_data, bus.req_ready, bus.grant_id, bus.busy, bus.timeout_pulse};
        exp = {e_tv, e_data, e_ready, e_grant, e_busy, e_pulse};
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s @%0t: got tv=%b data=%h ready=%b grant=%0d busy=%b pulse=%b, want tv=%b data=%h ready=%b grant=%0d busy=%b pulse=%b",
                     name, $time, act[16], act[15:8], act[7:4], act[3:2], act[1], act[0],
                     exp[16], exp[15:8], exp[7:4], exp[3:2], exp[1], exp[0]);
        end
        @(posedge clk_cac);
        #1;
    endtask

    // Convenience: one driven and checked cycle with the timeout flag expected low.
    task automatic cyc(input string name, input logic [3:0] v, input logic [31:0] d,
                       input logic [3:0] l, input logic txr, input logic e_tv,
                       input logic [7:0] e_data, input logic [3:0] e_ready,
                       input logic [1:0] e_grant, input logic e_busy);
        applyStimulus(1'b0, v, d, l, txr);
        checkOutput(name, e_tv, e_data, e_ready, e_grant, e_busy, 1'b0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        moved      = 0;

        // rst valid data{3,2,1,0} last txr | tv data ready grant busy
        vecs[0]  = '{1'b1, 4'b0000, 32'h00000000, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0};
        vecs[1]  = '{1'b0, 4'b0100, 32'h00A10000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0};
        vecs[2]  = '{1'b0, 4'b0100, 32'h00A10000, 4'b0000, 1'b1, 1'b1, 8'hA1, 4'b0100, 2'd2, 1'b1};
        vecs[3]  = '{1'b0, 4'b0100, 32'h00A20000, 4'b0000, 1'b1, 1'b1, 8'hA2, 4'b0100, 2'd2, 1'b1};
        vecs[4]  = '{1'b0, 4'b0100, 32'h00A30000, 4'b0100, 1'b1, 1'b1, 8'hA3, 4'b0100, 2'd2, 1'b1};
        vecs[5]  = '{1'b0, 4'b0000, 32'h00000000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd2, 1'b0};
        vecs[6]  = '{1'b1, 4'b0000, 32'h00000000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd2, 1'b0};
        vecs[7]  = '{1'b0, 4'b1111, 32'h13121110, 4'b1111, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0};
        vecs[8]  = '{1'b0, 4'b1111, 32'h13121110, 4'b1111, 1'b1, 1'b1, 8'h10, 4'b0001, 2'd0, 1'b1};
        vecs[9]  = '{1'b0, 4'b1110, 32'h13121110, 4'b1111, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0};
        vecs[10] = '{1'b0, 4'b1110, 32'h13121110, 4'b1111, 1'b1, 1'b1, 8'h11, 4'b0010, 2'd1, 1'b1};
        vecs[11] = '{1'b0, 4'b1100, 32'h13121110, 4'b1111, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd1, 1'b0};
        vecs[12] = '{1'b0, 4'b1100, 32'h13121110, 4'b1111, 1'b1, 1'b1, 8'h12, 4'b0100, 2'd2, 1'b1};
        vecs[13] = '{1'b0, 4'b1000, 32'h13121110, 4'b1111, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd2, 1'b0};
        vecs[14] = '{1'b0, 4'b1000, 32'h13121110, 4'b1111, 1'b1, 1'b1, 8'h13, 4'b1000, 2'd3, 1'b1};
        vecs[15] = '{1'b0, 4'b0000, 32'h13121110, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd3, 1'b0};

        // Reset preamble
        applyStimulus(1'b1, 4'b0000, 32'h0, 4'b0000, 1'b0);
        repeat (2) @(posedge clk_cac);
        #1;

        // Table: 3-byte packet from requester 2, then four 1-byte packets in rr order
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].last, vecs[i].txr);
            checkOutput($sformatf("vec%0d", i), vecs[i].e_tv, vecs[i].e_data, vecs[i].e_ready,
                        vecs[i].e_grant, vecs[i].e_busy, 1'b0);
        end

        // Requester 1 holds the UART for 4 bytes although requester 0 is valid throughout
        cyc("lock_grant",  4'b0010, 32'h00000031, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd3, 1'b0);
        cyc("lock_b1",     4'b0011, 32'h00003140, 4'b0001, 1'b1, 1'b1, 8'h31, 4'b0010, 2'd1, 1'b1);
        cyc("lock_b2",     4'b0011, 32'h00003240, 4'b0001, 1'b1, 1'b1, 8'h32, 4'b0010, 2'd1, 1'b1);
        cyc("lock_b3",     4'b0011, 32'h00003340, 4'b0001, 1'b1, 1'b1, 8'h33, 4'b0010, 2'd1, 1'b1);
        cyc("lock_b4",     4'b0011, 32'h00003440, 4'b0011, 1'b1, 1'b1, 8'h34, 4'b0010, 2'd1, 1'b1);
        cyc("lock_bubble", 4'b0001, 32'h00000040, 4'b0001, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd1, 1'b0);
        cyc("lock_next0",  4'b0001, 32'h00000040, 4'b0001, 1'b1, 1'b1, 8'h40, 4'b0001, 2'd0, 1'b1);

        // tx_ready held low for 5 cycles in the middle of a requester-2 packet
        cyc("bp_grant", 4'b0100, 32'h00B10000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0);
        cyc("bp_b1",    4'b0100, 32'h00B10000, 4'b0000, 1'b1, 1'b1, 8'hB1, 4'b0100, 2'd2, 1'b1);
        for (int s = 0; s < 5; s++) begin
            cyc($sformatf("bp_hold%0d", s), 4'b0100, 32'h00B20000, 4'b0000, 1'b0,
                1'b1, 8'hB2, 4'b0000, 2'd2, 1'b1);
        end
        cyc("bp_b2",   4'b0100, 32'h00B20000, 4'b0000, 1'b1, 1'b1, 8'hB2, 4'b0100, 2'd2, 1'b1);
        cyc("bp_b3",   4'b0100, 32'h00B30000, 4'b0100, 1'b1, 1'b1, 8'hB3, 4'b0100, 2'd2, 1'b1);
        cyc("bp_idle", 4'b0000, 32'h00000000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd2, 1'b0);

        // Synchronous reset after byte 2 of a requester-3 packet
        cyc("rst_grant", 4'b1000, 32'hC1000000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd2, 1'b0);
        cyc("rst_b1",    4'b1000, 32'hC1000000, 4'b0000, 1'b1, 1'b1, 8'hC1, 4'b1000, 2'd3, 1'b1);
        cyc("rst_b2",    4'b1000, 32'hC2000000, 4'b0000, 1'b1, 1'b1, 8'hC2, 4'b1000, 2'd3, 1'b1);
        applyStimulus(1'b1, 4'b1000, 32'hC3000000, 4'b0000, 1'b1);
        checkOutput("rst_cycle", 1'b1, 8'hC3, 4'b1000, 2'd3, 1'b1, 1'b0);
        cyc("rst_after", 4'b0000, 32'h00000000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0);
        cyc("rst_req",   4'b1010, 32'hC10000F1, 4'b0010, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0);
        cyc("rst_ptr0",  4'b1010, 32'hC100F100, 4'b0010, 1'b1, 1'b1, 8'hF1, 4'b0010, 2'd1, 1'b1);
        cyc("rst_idle",  4'b0000, 32'h00000000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd1, 1'b0);

        // Requester 0 stalls after byte 1 while requester 1 waits
        cyc("stall_grant", 4'b0001, 32'h000000D1, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd1, 1'b0);
        cyc("stall_b1",    4'b0011, 32'h0000E1D1, 4'b0010, 1'b1, 1'b1, 8'hD1, 4'b0001, 2'd0, 1'b1);
`ifdef CAC_UART_ARB_TIMEOUT_EN
        for (int s = 1; s <= TO; s++) begin
            cyc($sformatf("stall_wait%0d", s), 4'b0010, 32'h0000E1D2, 4'b0010, 1'b1,
                1'b0, 8'hD2, 4'b0001, 2'd0, 1'b1);
        end
        applyStimulus(1'b0, 4'b0010, 32'h0000E1D2, 4'b0010, 1'b1);
        checkOutput("stall_timeout", 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0, 1'b1);
        cyc("stall_next1", 4'b0010, 32'h0000E1D2, 4'b0010, 1'b1, 1'b1, 8'hE1, 4'b0010, 2'd1, 1'b1);
        cyc("stall_idle",  4'b0000, 32'h00000000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd1, 1'b0);
`else
        for (int s = 1; s <= TO + 4; s++) begin
            cyc($sformatf("stall_hold%0d", s), 4'b0010, 32'h0000E1D2, 4'b0010, 1'b1,
                1'b0, 8'hD2, 4'b0001, 2'd0, 1'b1);
        end
        cyc("stall_b2",    4'b0011, 32'h0000E1D2, 4'b0011, 1'b1, 1'b1, 8'hD2, 4'b0001, 2'd0, 1'b1);
        cyc("stall_bub",   4'b0010, 32'h0000E1D2, 4'b0010, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0);
        cyc("stall_next1", 4'b0010, 32'h0000E1D2, 4'b0010, 1'b1, 1'b1, 8'hE1, 4'b0010, 2'd1, 1'b1);
        cyc("stall_idle",  4'b0000, 32'h00000000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd1, 1'b0);
`endif

        // Randomized traffic against the packet-level reference model
        applyStimulus(1'b1, 4'b0000, 32'h0, 4'b0000, 1'b0);
        checkOutput("rand_pre_reset", 1'b0, 8'h00, 4'b0000, 2'd1, 1'b0, 1'b0);
        m_owner = -1;
        m_ptr   = 0;
        m_grant = 0;
        m_stall = 0;
        m_pulse = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            cur_byte[i] = 8'($urandom_range(255));
            remain[i]   = $urandom_range(1, 4);
        end
        for (int c = 0; c < 600; c++) begin
            logic [3:0]  v;
            logic [31:0] d;
            logic [3:0]  l;
            logic        txr;
            logic        e_tv;
            logic [7:0]  e_data;
            logic [3:0]  e_ready;
            for (int i = 0; i < NREQ; i++) begin
                v[i]          = ($urandom_range(3) != 0);
                d[i*DW +: DW] = cur_byte[i];
                l[i]          = (remain[i] == 1);
            end
            txr = ($urandom_range(3) != 0);
            if (m_owner < 0) begin
                e_tv    = 1'b0;
                e_data  = 8'h00;
                e_ready = 4'b0000;
            end else begin
                e_tv    = v[m_owner];
                e_data  = d[m_owner*DW +: DW];
                e_ready = txr ? 4'(1 << m_owner) : 4'b0000;
            end
            applyStimulus(1'b0, v, d, l, txr);
            checkOutput("random", e_tv, e_data, e_ready, 2'(m_grant), (m_owner >= 0), m_pulse);

            m_pulse = 1'b0;
            if (m_owner < 0) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (m_owner < 0 && v[(m_ptr + k) % NREQ]) begin
                        m_owner = (m_ptr + k) % NREQ;
                        m_grant = m_owner;
                        m_stall = 0;
                    end
                end
            end else if (v[m_owner] && txr) begin
                int o;
                o = m_owner;
                moved++;
                m_stall     = 0;
                cur_byte[o] = cur_byte[o] + 8'd1;
                remain[o]   = remain[o] - 1;
                if (remain[o] == 0) begin
                    remain[o]   = $urandom_range(1, 4);
                    cur_byte[o] = 8'($urandom_range(255));
                end
                if (l[o]) begin
                    m_owner = -1;
                    m_ptr   = (o + 1) % NREQ;
                end
            end else begin
`ifdef CAC_UART_ARB_TIMEOUT_EN
                m_stall++;
                if (m_stall == TO) begin
                    m_pulse = 1'b1;
                    m_ptr   = (m_owner + 1) % NREQ;
                    m_owner = -1;
                end
`endif
            end
        end

        compared++;
        if (moved < 50) begin
            mismatched++;
            $display("[TB] FAIL random_activity: got %0d bytes moved, want at least 50", moved);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
